// File: rtl/ula_arbiter.sv
// ---------------------------------------------------------------------------
// ula_arbiter
//
// Purpose
//   Shares one purely combinational 8-bit ULA between two requesters. Each
//   requester hands over one operation through a valid/ready handshake
//   (reqN/gntN). The arbiter registers the operands and drives the ULA from
//   those registers for one cycle. It then captures the ULA result and zero
//   flag and strobes doneN for the owning requester.
//
//   Sequence: IDLE (arbitrate / accept) -> EXEC (ULA driven, result captured
//   on the edge) -> DONE (one-cycle done strobe) -> IDLE.
//   Accept-to-done latency is 2 cycles. Throughput is 1 op per 3 cycles.
//
// Optional feature (macro ULA_ARB_OPCHK_EN)
//   When the macro is defined, opcodes 110/111 are still accepted and
//   sequenced normally. At capture they produce res = 0, zero = 0, err = 1.
//   When the macro is undefined, the opcode is forwarded untouched and err is
//   always 0.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous reset, active-high
//   req0/req1      in   requester valid; operands held stable until accepted
//   opa0/opb0      in   [7:0] requester 0 operands
//   opa1/opb1      in   [7:0] requester 1 operands
//   ctl0/ctl1      in   [2:0] ULA opcode
//                       (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt)
//   gnt0/gnt1      out  combinational ready; transfer when reqN & gntN
//   done0/done1    out  one-cycle result strobe for the owning requester
//   res            out  [7:0] registered result, qualified by done0/done1
//   zero           out  registered ULA zero flag
//   err            out  illegal-opcode flag, valid with done
//   alu_a/alu_b    out  [7:0] to ULA SrcA/SrcB
//   alu_ctl        out  [2:0] to ULA ULAControl
//   alu_res        in   [7:0] from ULA result
//   alu_z          in   from ULA zero flag
// ---------------------------------------------------------------------------
module ula_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] opa0,
    input  logic [7:0] opb0,
    input  logic [2:0] ctl0,
    output logic       gnt0,
    output logic       done0,
    input  logic       req1,
    input  logic [7:0] opa1,
    input  logic [7:0] opb1,
    input  logic [2:0] ctl1,
    output logic       gnt1,
    output logic       done1,
    output logic [7:0] res,
    output logic       zero,
    output logic       err,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_ctl,
    input  logic [7:0] alu_res,
    input  logic       alu_z
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_q,  last_d;   // requester served most recently
    logic       owner_q, owner_d;  // requester that owns the op in flight
    logic [7:0] opa_q,   opa_d;
    logic [7:0] opb_q,   opb_d;
    logic [2:0] ctl_q,   ctl_d;
    logic [7:0] res_q,   res_d;
    logic       zero_q,  zero_d;
    logic       err_q,   err_d;

    logic       win1;              // 1 when requester 1 wins arbitration

    // -----------------------------------------------------------------------
    // Arbitration. A lone request always wins. On a tie, the requester that
    // was not served last wins, which yields strict alternation 0,1,0,1...
    // Grants are forced low during reset so nothing can be accepted while
    // the state is being cleared.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        win1 = 1'b0;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            win1 = ~last_q;
        end else begin
            win1 = req1;
        end
        if (!rst && (state_q == S_IDLE)) begin
            gnt0 = req0 & ~win1;
            gnt1 = req1 &  win1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state / datapath update.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        ctl_d   = ctl_q;
        res_d   = res_q;
        zero_d  = zero_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (gnt0) begin
                    opa_d   = opa0;
                    opb_d   = opb0;
                    ctl_d   = ctl0;
                    owner_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_EXEC;
                end else if (gnt1) begin
                    opa_d   = opa1;
                    opb_d   = opb1;
                    ctl_d   = ctl1;
                    owner_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
`ifdef ULA_ARB_OPCHK_EN
                // Opcodes 11x have no ULA operation. Flag them and replace
                // the ULA's default output with res = 0, zero = 0.
                if (ctl_q[2:1] == 2'b11) begin
                    res_d  = 8'h00;
                    zero_d = 1'b0;
                    err_d  = 1'b1;
                end else begin
                    res_d  = alu_res;
                    zero_d = alu_z;
                    err_d  = 1'b0;
                end
`else
                res_d  = alu_res;
                zero_d = alu_z;
                err_d  = 1'b0;
`endif
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: every register here holds control or visible output state,
        // so all of them are reset. last resets to 1 so that requester 0 wins
        // the first tie.
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples its pre-edge value regardless of statement order.
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            opa_q   <= 8'h00;
            opb_q   <= 8'h00;
            ctl_q   <= 3'b000;
            res_q   <= 8'h00;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ctl_q   <= ctl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. The ULA inputs come straight from the operand registers. They
    // keep the last operands outside EXEC, which is harmless because the ULA
    // is combinational. done is masked by rst, so a reset during DONE aborts
    // the operation without a strobe.
    // -----------------------------------------------------------------------
    assign alu_a   = opa_q;
    assign alu_b   = opb_q;
    assign alu_ctl = ctl_q;

    assign done0 = !rst && (state_q == S_DONE) && !owner_q;
    assign done1 = !rst && (state_q == S_DONE) &&  owner_q;

    assign res  = res_q;
    assign zero = zero_q;
    assign err  = err_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ula_arbiter
//
// Directed self-checking bench for ula_arbiter. The bench models the
// combinational ULA locally. Inputs change 1 time unit after each rising
// edge, and outputs are sampled in the same window, away from the edge.
// ---------------------------------------------------------------------------
module tb_ula_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] opa0, opb0, opa1, opb1;
    logic [2:0] ctl0, ctl1;
    logic       gnt0, gnt1, done0, done1;
    logic [7:0] res;
    logic       zero, err;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_ctl;
    logic [7:0] alu_res;
    logic       alu_z;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ula_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .opa0(opa0), .opb0(opb0), .ctl0(ctl0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .opa1(opa1), .opb1(opb1), .ctl1(ctl1), .gnt1(gnt1), .done1(done1),
        .res(res), .zero(zero), .err(err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .alu_res(alu_res), .alu_z(alu_z)
    );

    // Reference ULA: slt is signed. Opcodes 11x yield 0, so the zero flag is 1.
    always_comb begin
        alu_res = 8'h00;
        case (alu_ctl)
            3'b000: alu_res = alu_a + alu_b;
            3'b001: alu_res = alu_a - alu_b;
            3'b010: alu_res = alu_a & alu_b;
            3'b011: alu_res = alu_a | alu_b;
            3'b100: alu_res = alu_a ^ alu_b;
            3'b101: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 8'h01 : 8'h00;
            default: alu_res = 8'h00;
        endcase
        alu_z = (alu_res == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; opa0 = 8'h00; opb0 = 8'h00; ctl0 = 3'b000;
        req1 = 1'b0; opa1 = 8'h00; opb1 = 8'h00; ctl1 = 3'b000;

        // ---------------- reset ----------------
        step(); step();
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        req0 = 1'b0; req1 = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("rst_res", res, 8'h00);
        check("rst_zero", zero, 0);
        check("rst_err", err, 0);
        check("rst_done", {done1, done0}, 2'b00);
        check("rst_alu", {alu_a, alu_b, alu_ctl}, 19'h0);

        // ---------------- single op: 05 + 03 ----------------
        req0 = 1'b1; opa0 = 8'h05; opb0 = 8'h03; ctl0 = 3'b000;
        #1;
        check("single_gnt", {gnt1, gnt0}, 2'b01);
        step();                                   // C+1 EXEC
        req0 = 1'b0;
        check("single_alu", {alu_a, alu_b, alu_ctl}, {8'h05, 8'h03, 3'b000});
        check("single_exec_gnt", {gnt1, gnt0}, 2'b00);
        step();                                   // C+2 DONE
        check("single_done", {done1, done0}, 2'b01);
        check("single_res", res, 8'h08);
        check("single_zero", zero, 0);
        step();                                   // IDLE
        check("single_done_off", {done1, done0}, 2'b00);

        // ---------------- zero flag: 2A - 2A ----------------
        req1 = 1'b1; opa1 = 8'h2A; opb1 = 8'h2A; ctl1 = 3'b001;
        #1;
        check("zero_gnt", {gnt1, gnt0}, 2'b10);
        step();
        req1 = 1'b0;
        step();
        check("zero_done", {done1, done0}, 2'b10);
        check("zero_res", res, 8'h00);
        check("zero_flag", zero, 1);
        step();

        // ---------------- fairness: both held ----------------
        // Requester 1 was served last, so requester 0 takes the first tie.
        req0 = 1'b1; opa0 = 8'h03; opb0 = 8'h07; ctl0 = 3'b101;   // slt -> 01
        req1 = 1'b1; opa1 = 8'hF0; opb1 = 8'h0F; ctl1 = 3'b011;   // or  -> FF
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fair%0d_gnt", i), {gnt1, gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
            check($sformatf("fair%0d_exec_gnt", i), {gnt1, gnt0}, 2'b00);
            step();
            check($sformatf("fair%0d_done", i), {done1, done0}, (i % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("fair%0d_res", i), res, (i % 2 == 0) ? 8'h01 : 8'hFF);
            check($sformatf("fair%0d_zero", i), zero, 0);
            step();
        end
        req0 = 1'b0; req1 = 1'b0;

        // ---------------- back-pressure ----------------
        req0 = 1'b1; opa0 = 8'h10; opb0 = 8'h01; ctl0 = 3'b100;   // xor -> 11
        #1;
        check("bp_gnt0", gnt0, 1);
        step();                                                   // EXEC
        req0 = 1'b0;
        req1 = 1'b1; opa1 = 8'h09; opb1 = 8'h04; ctl1 = 3'b001;   // sub -> 05
        #1;
        check("bp_exec_gnt1", gnt1, 0);
        step();                                                   // DONE
        check("bp_done_gnt1", gnt1, 0);
        check("bp_done0", {done1, done0}, 2'b01);
        check("bp_res0", res, 8'h11);
        step();                                                   // IDLE, C+3
        check("bp_idle_gnt1", {gnt1, gnt0}, 2'b10);
        step();
        req1 = 1'b0;
        step();
        check("bp_done1", {done1, done0}, 2'b10);
        check("bp_res1", res, 8'h05);
        step();

        // ---------------- reset during EXEC ----------------
        req0 = 1'b1; opa0 = 8'h01; opb0 = 8'h01; ctl0 = 3'b000;
        #1;
        check("rexec_gnt0", gnt0, 1);
        step();                                                   // EXEC
        req0 = 1'b0;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rexec_done", {done1, done0}, 2'b00);
        check("rexec_res", res, 8'h00);
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("rexec_tie_gnt", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0; req1 = 1'b0;
        #1;
        step();
        check("rexec_no_done", {done1, done0}, 2'b00);

        // ---------------- reset during DONE ----------------
        req0 = 1'b1; opa0 = 8'h01; opb0 = 8'h01; ctl0 = 3'b000;
        step();
        req0 = 1'b0;
        step();                                                   // DONE
        rst = 1'b1;
        #1;
        check("rdone_done", {done1, done0}, 2'b00);
        step();
        rst = 1'b0;
        #1;
        check("rdone_res", res, 8'h00);
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("rdone_tie_gnt", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0; req1 = 1'b0;
        #1;

        // ---------------- opcode 111 ----------------
        req1 = 1'b1; opa1 = 8'h55; opb1 = 8'hAA; ctl1 = 3'b111;
        #1;
        check("op7_gnt", gnt1, 1);
        step();
        req1 = 1'b0;
        check("op7_alu_ctl", alu_ctl, 3'b111);
        step();
        check("op7_done", {done1, done0}, 2'b10);
        check("op7_res", res, 8'h00);
`ifdef ULA_ARB_OPCHK_EN
        check("op7_err", err, 1);
        check("op7_zero", zero, 0);
`else
        check("op7_err", err, 0);
        check("op7_zero", zero, 1);
`endif
        step();

        // Legal op after the illegal one: err must clear at capture.
        req0 = 1'b1; opa0 = 8'hC0; opb0 = 8'h3F; ctl0 = 3'b010;   // and -> 00
        step();
        req0 = 1'b0;
        step();
        check("legal_done", {done1, done0}, 2'b01);
        check("legal_err", err, 0);
        check("legal_res", res, 8'h00);
        check("legal_zero", zero, 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
